ex_mem_pipe: RTL and testbench
==============================

Name: ex_mem_pipe

Overview:
- EX/MEM pipeline register with a 2-entry skid buffer.
- Sits between the execute stage and MEM_stage and carries the ALU result, store data, destination register and memory/writeback control bits.
- Uses a valid/ready handshake on both sides, so a MEM-side stall (multi-cycle data memory) does not combinationally reach back into EX.
- Supports flush for branch/exception squash.

Parameters:
- DATA_W, 32, width of alu_result and write_data
- REG_W, 5, width of destination register index

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- flush  input  1  squash all held entries
- in_valid  input  1  EX presents an instruction
- in_ready  output  1  register can accept; registered, depends only on state
- in_alu_result  input  DATA_W  address / ALU value
- in_write_data  input  DATA_W  store data
- in_rd  input  REG_W  destination register
- in_ctrl  input  4  {regwrite, memtoreg, memread, memwrite}
- out_valid  output  1  MEM stage has a valid instruction
- out_ready  input  1  MEM consumes this cycle
- out_alu_result  output  DATA_W
- out_write_data  output  DATA_W
- out_rd  output  REG_W
- out_ctrl  output  4
- stall_cnt  output  32  only with the optional feature; tied to 0 otherwise

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. rst has priority over everything.
- Storage: a main entry (drives out_*) and a skid entry. Each has a valid bit and the full payload.
- Reset values: main_valid=0, skid_valid=0, all payload regs 0. Hence out_valid=0, out_* all 0, in_ready=1, stall_cnt=0.
- Transfers:
  - Accept = in_valid & in_ready.
  - Drain = out_valid & out_ready.
- Latency: an accepted instruction appears on out_* the next cycle when main is empty or draining.
- Per-cycle update, in priority order after rst:
  - flush=1: main_valid<=0 and skid_valid<=0. An input accepted in the same cycle is dropped. in_ready=1 next cycle. Payload regs may hold stale data; out_valid is 0.
  - Main empty or draining:
    - If skid_valid: main<=skid. skid<=input if accepting, else skid_valid<=0.
    - Otherwise: main<=input with main_valid<=accept.
  - Main full and not draining: an accepted input goes to skid (skid_valid<=1).
- in_ready = ~skid_valid. It is a flop-derived signal with no combinational path from out_ready.
- State view:
  - EMPTY (0 entries).
  - ONE (main only).
  - FULL (main+skid). FULL is reachable only by accept while main is not draining. In FULL, in_ready=0.
- Ordering: strict FIFO; no instruction is duplicated or lost except by flush.
- Zero-register rule: at capture, if in_rd==0 then the stored regwrite bit is forced to 0. The other bits pass unchanged.
- Sanitising: when out_valid=0, out_ctrl is forced to 4'b0. This prevents a spurious memwrite. out_alu_result, out_write_data and out_rd keep their last values.
- out_* payload is stable while out_valid=1 & out_ready=0.
- Simultaneous accept and drain in ONE: main takes the input and skid stays empty.
- Simultaneous accept and drain in FULL: main<=skid and skid<=input. This case is unreachable, since in_ready=0 in FULL; treat it as a defensive path.

Optional Feature:
- Macro EX_MEM_STALL_CNT_EN.
- Defined:
  - stall_cnt is a 32-bit counter, cleared by rst.
  - It increments every cycle with out_valid=1 & out_ready=0.
  - It wraps from 0xFFFFFFFF to 0.
  - flush does not clear it.
- Undefined: no counter flops; stall_cnt is driven constant 0.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → out_valid=0, out_ctrl=0, in_ready=1, stall_cnt=0.
- Streaming, out_ready=1:
  - Stimulus: send alu_result 0x10, 0x20, 0x30 on consecutive cycles with rd=3, ctrl=4'b1000.
  - Required: out shows 0x10, 0x20, 0x30 on the following three cycles, out_valid continuous, in_ready always 1.
- Backpressure:
  - Stimulus: out_ready=0, send 0xA then 0xB.
  - Required: after 0xB is accepted, in_ready=0 and out holds 0xA stable. Raising out_ready drains 0xA then 0xB in order. in_ready=1 the cycle after 0xA drains.
- Flush while FULL:
  - Stimulus: two entries held, then flush=1 with in_valid=1, alu_result=0xC.
  - Required: next cycle out_valid=0, out_ctrl=0, in_ready=1, and 0xC never appears.
- Zero register:
  - Stimulus: in_rd=0, ctrl=4'b1010.
  - Required: out_ctrl=4'b0010.
  - Stimulus: in_rd=7, ctrl=4'b1010.
  - Required: out_ctrl=4'b1010.
- Counter (with EX_MEM_STALL_CNT_EN):
  - Stimulus: hold one entry with out_ready=0 for 5 cycles.
  - Required: stall_cnt=5. A mid-test rst returns it to 0.

Source files
------------

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with a 2-entry skid buffer: main entry drives out_*, skid absorbs one extra.
// Optional stall counter enabled by defining EX_MEM_STALL_CNT_EN.
module ex_mem_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_write_data,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [3:0]        in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_write_data,
  output logic [REG_W-1:0]  out_rd,
  output logic [3:0]        out_ctrl,
  output logic [31:0]       stall_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] wdata;
    logic [REG_W-1:0]  rd;
    logic [3:0]        ctrl;
  } ent_t;

  ent_t main_q, main_d, skid_q, skid_d, in_ent;
  logic main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic accept, drain;

  assign in_ready = ~skid_vld_q;
  assign accept   = in_valid & in_ready;
  assign drain    = main_vld_q & out_ready;

  // Writes to x0 are architecturally dropped, so regwrite is cleared at capture.
  always_comb begin
    in_ent.alu   = in_alu_result;
    in_ent.wdata = in_write_data;
    in_ent.rd    = in_rd;
    in_ent.ctrl  = in_ctrl;
    if (in_rd == '0) in_ent.ctrl[3] = 1'b0;
  end

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || drain) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = accept;
        if (accept) skid_d = in_ent;
      end else begin
        main_vld_d = accept;
        if (accept) main_d = in_ent;
      end
    end else if (accept) begin
      skid_d     = in_ent;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign out_valid      = main_vld_q;
  assign out_alu_result = main_q.alu;
  assign out_write_data = main_q.wdata;
  assign out_rd         = main_q.rd;
  // Idle slots must never present a memwrite to the memory stage.
  assign out_ctrl       = main_vld_q ? main_q.ctrl : 4'b0;

`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else if (main_vld_q && !out_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
  end
  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Randomized + directed bench for ex_mem_pipe against a queue-based FIFO model.
module tb_ex_mem_pipe;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_alu_result, in_write_data, out_alu_result, out_write_data, stall_cnt;
  logic [4:0]  in_rd, out_rd;
  logic [3:0]  in_ctrl, out_ctrl;

  always #5 clk = ~clk;

  ex_mem_pipe #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_result(in_alu_result), .in_write_data(in_write_data),
    .in_rd(in_rd), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_result(out_alu_result), .out_write_data(out_write_data),
    .out_rd(out_rd), .out_ctrl(out_ctrl), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] w;
    logic [4:0]  rd;
    logic [3:0]  c;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_cnt;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_check();
    chk("out_valid", out_valid, mq.size() > 0);
    chk("in_ready", in_ready, mq.size() < 2);
    if (mq.size() > 0) begin
      chk("out_alu", out_alu_result, mq[0].a);
      chk("out_wdata", out_write_data, mq[0].w);
      chk("out_rd", out_rd, mq[0].rd);
      chk("out_ctrl", out_ctrl, mq[0].c);
    end else begin
      chk("out_ctrl_idle", out_ctrl, 4'b0);
    end
`ifdef EX_MEM_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, m_cnt);
`else
    chk("stall_cnt", stall_cnt, 32'd0);
`endif
  endtask

  // One clock: drive inputs, advance model at the edge, compare on the falling edge.
  task automatic cycle(input logic r, input logic f, input logic iv, input logic [31:0] a,
                       input logic [31:0] w, input logic [4:0] rd, input logic [3:0] c,
                       input logic ordy);
    ent_t e;
    bit   acc, drn;
    rst = r; flush = f; in_valid = iv; in_alu_result = a; in_write_data = w;
    in_rd = rd; in_ctrl = c; out_ready = ordy;
    @(posedge clk);
    acc = iv && (mq.size() < 2);
    drn = (mq.size() > 0) && ordy;
    if (r) begin
      mq.delete();
      m_cnt = 0;
    end else begin
      if (mq.size() > 0 && !ordy) m_cnt = m_cnt + 1;
      if (f) mq.delete();
      else begin
        if (drn) void'(mq.pop_front());
        if (acc) begin
          e.a = a; e.w = w; e.rd = rd;
          e.c = (rd == 0) ? (c & 4'b0111) : c;
          mq.push_back(e);
        end
      end
    end
    @(negedge clk);
    model_check();
  endtask

  task automatic send(input logic [31:0] a, input logic [4:0] rd, input logic [3:0] c, input logic ordy);
    cycle(1'b0, 1'b0, 1'b1, a, ~a, rd, c, ordy);
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 4'h0, ordy);
  endtask

  initial begin
    m_cnt = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_alu_result = '0; in_write_data = '0; in_rd = '0; in_ctrl = '0;

    // reset, then idle
    cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_ctrl", out_ctrl, 4'b0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);

    // streaming
    send(32'h10, 5'd3, 4'b1000, 1'b1);
    chk("stream0", out_alu_result, 32'h10);
    send(32'h20, 5'd3, 4'b1000, 1'b1);
    chk("stream1", out_alu_result, 32'h20);
    chk("stream_rdy", in_ready, 1'b1);
    send(32'h30, 5'd3, 4'b1000, 1'b1);
    chk("stream2", out_alu_result, 32'h30);
    chk("stream_vld", out_valid, 1'b1);
    idle(1'b1);

    // backpressure
    send(32'hA, 5'd4, 4'b0001, 1'b0);
    send(32'hB, 5'd4, 4'b0001, 1'b0);
    chk("bp_full_rdy", in_ready, 1'b0);
    chk("bp_hold", out_alu_result, 32'hA);
    idle(1'b0);
    chk("bp_stable", out_alu_result, 32'hA);
    idle(1'b1);
    chk("bp_drainB", out_alu_result, 32'hB);
    chk("bp_rdy_back", in_ready, 1'b1);
    idle(1'b1);
    chk("bp_empty", out_valid, 1'b0);

    // flush while full, with a concurrent input that must be dropped
    send(32'h1, 5'd2, 4'b0001, 1'b0);
    send(32'h2, 5'd2, 4'b0001, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 32'hC, 32'h0, 5'd5, 4'b0001, 1'b0);
    chk("fl_vld", out_valid, 1'b0);
    chk("fl_ctrl", out_ctrl, 4'b0);
    chk("fl_rdy", in_ready, 1'b1);
    idle(1'b1);
    chk("fl_noC", out_valid, 1'b0);

    // zero register rule
    send(32'h40, 5'd0, 4'b1010, 1'b1);
    chk("x0_ctrl", out_ctrl, 4'b0010);
    send(32'h44, 5'd7, 4'b1010, 1'b1);
    chk("x7_ctrl", out_ctrl, 4'b1010);
    idle(1'b1);

`ifdef EX_MEM_STALL_CNT_EN
    cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    send(32'h50, 5'd1, 4'b1000, 1'b0);
    repeat (5) idle(1'b0);
    chk("cnt5", stall_cnt, 32'd5);
    cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    chk("cnt_rst", stall_cnt, 32'd0);
`endif

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      logic [4:0]  rd;
      a  = $urandom;
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) != 0), a, $urandom, rd, 4'($urandom),
            ($urandom_range(0, 2) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
